mul8_csa_seq: RTL and testbench

Iterative 8x8 unsigned multiplier front-end that feeds the 16-bit final carry-lookahead adder (`cla`). It accepts one operand pair per transaction and runs one partial-product row per cycle through a carry-save accumulator, retiring one resolved low product bit per step. After 8 steps it presents a redundant (sum, carry) pair on `x`, `y`, `cin`, shaped for `cla`, so that `cla.sum` equals the exact 16-bit product. The block does not instantiate `cla`; the parent connects `x`/`y`/`cin` straight to it.

---
 rtl/mul_pkg.sv | 17 +
 rtl/csa_row8.sv | 17 +
 rtl/mul8_csa_seq.sv | 114 +++++++++++
 tb/tb_mul8_csa_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative 8x8 carry-save multiplier front-end.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int MUL_W     = 8;
    localparam int PROD_W    = 16;
    localparam int CLA_Y_W   = 14;
    localparam int CLA_Y_OFS = 2;
    localparam int STEPS     = 8;
    localparam int CNT_W     = 3;

endpackage

// File: rtl/csa_row8.sv
// One carry-save row: eight independent full adders reducing (S, C, pp) to (s, c).
module csa_row8
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0] i_s,
    input  logic [MUL_W-1:0] i_c,
    input  logic [MUL_W-1:0] i_pp,
    output logic [MUL_W-1:0] o_s,
    output logic [MUL_W-1:0] o_c
);

    always_comb begin
        o_s = i_s ^ i_c ^ i_pp;
        o_c = (i_s & i_c) | (i_s & i_pp) | (i_c & i_pp);
    end

endmodule

// File: rtl/mul8_csa_seq.sv
// Iterative 8x8 unsigned multiplier: one partial-product row per cycle into a
// carry-save accumulator, result left in redundant form for the 16-bit cla.
module mul8_csa_seq
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   x,
    output logic [CLA_Y_W-1:0]  y,
    output logic                cin
);

    mul_state_t       r_state;
    mul_state_t       w_state_nxt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_s;
    logic [W-1:0]     r_c;
    logic [W-1:0]     r_l;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     w_pp;
    logic [W-1:0]     w_s;
    logic [W-1:0]     w_c;
    logic             w_load;
    logic             w_step;

    assign w_pp = r_a & {W{r_b[0]}};

    csa_row8 u_row (
        .i_s  (r_s),
        .i_c  (r_c),
        .i_pp (w_pp),
        .o_s  (w_s),
        .o_c  (w_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(STEPS - 1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // s[0] is final after each row, so it retires into L; the remaining sum
    // bits shift down one place to stay aligned with the carries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
            r_c   <= '0;
            r_l   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_s   <= '0;
            r_c   <= '0;
            r_l   <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_s   <= {1'b0, w_s[W-1:1]};
            r_c   <= w_c;
            r_l   <= {w_s[0], r_l[W-1:1]};
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // C sits at weight 2^W; the cla y port starts at 2^CLA_Y_OFS, hence the zero pad.
    assign x   = {r_s, r_l};
    assign y   = {r_c, {(CLA_Y_W - W){1'b0}}};
    assign cin = 1'b0;

endmodule

// File: tb/tb_mul8_csa_seq.sv
// Scoreboard bench for mul8_csa_seq: driver queues hand-computed products,
// monitor checks each presented result through a behavioural cla model.
module tb_mul8_csa_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x;
    logic [13:0] y;
    logic        cin;

    mul8_csa_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .cin       (cin)
    );

    typedef struct {
        logic [15:0] exp;
        int          acc;
        bit          zero_chk;
        bit          lsb_chk;
        bit          seen;
    } txn_t;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] vp;
    } vec_t;

    txn_t q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle a result is presented it must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_result: got x=0x%0h y=0x%0h required no result", x, y);
            end else begin
                logic [15:0] cla_sum;
                cla_sum = x + {y, 2'b00} + 16'(cin);
                chk("cla_sum", 32'(cla_sum), 32'(q[0].exp));
                chk("cin_zero", 32'(cin), 32'd0);
                if (!q[0].seen) begin
                    chk("latency", 32'(cyc - q[0].acc + 1), 32'd9);
                    if (q[0].zero_chk) begin
                        chk("x_zero", 32'(x), 32'd0);
                        chk("y_zero", 32'(y), 32'd0);
                    end
                    if (q[0].lsb_chk) chk("x_lsbs", 32'(x[1:0]), 32'd1);
                    q[0].seen = 1'b1;
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    n_done++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] e,
                        input bit zc, input bit lc, input bit push, output int acc);
        txn_t t;
        int   guard;
        guard = 0;
        acc   = -1;
        @(negedge clk);
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("send_timeout_in_ready", 32'(in_ready), 32'd1);
        end else begin
            a        = ta;
            b        = tb;
            in_valid = 1'b1;
            acc      = cyc + 1;
            if (push) begin
                t.exp = e; t.acc = acc; t.zero_chk = zc; t.lsb_chk = lc; t.seen = 1'b0;
                q.push_back(t);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        int guard;
        guard = 0;
        while (n_done < target && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (n_done < target) chk("result_timeout", 32'(n_done), 32'(target));
    endtask

    vec_t vecs[8];
    int   acc1, acc2, expect_done;
    logic [15:0] hx;
    logic [13:0] hy;

    initial begin
        vecs[0] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[1] = '{8'hFF, 8'h01, 16'h00FF};
        vecs[2] = '{8'h10, 8'h10, 16'h0100};
        vecs[3] = '{8'hAA, 8'h55, 16'h3872};
        vecs[4] = '{8'h0F, 8'h0F, 16'h00E1};
        vecs[5] = '{8'h80, 8'h80, 16'h4000};
        vecs[6] = '{8'hFE, 8'h03, 16'h02FA};
        vecs[7] = '{8'hC3, 8'h00, 16'h0000};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        expect_done = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_cin", 32'(cin), 32'd0);
        rst = 1'b0;

        send(8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1, 1'b1, acc1);
        wait_done(++expect_done);
        send(8'h00, 8'hA5, 16'h0000, 1'b1, 1'b0, 1'b1, acc1);
        wait_done(++expect_done);

        // Held result: stable outputs, no acceptance of a new pair.
        out_ready = 1'b0;
        send(8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 1'b1, acc1);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        hx = x;
        hy = y;
        a = 8'h55; b = 8'h55; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_x", 32'(x), 32'(hx));
            chk("hold_y", 32'(y), 32'(hy));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done(++expect_done);
        repeat (12) @(negedge clk);
        chk("hold_back_idle", 32'(in_ready), 32'd1);

        send(8'h12, 8'h34, 16'h03A8, 1'b0, 1'b0, 1'b1, acc1);
        send(8'h80, 8'h02, 16'h0100, 1'b0, 1'b0, 1'b1, acc2);
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd10);
        expect_done += 2;
        wait_done(expect_done);

        // Reset in RUN cycle 4 drops the transaction.
        send(8'h21, 8'h43, 16'h0000, 1'b0, 1'b0, 1'b0, acc1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_run_out_valid", 32'(out_valid), 32'd0);
        chk("rst_run_in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(negedge clk);
        send(8'h07, 8'h06, 16'h002A, 1'b0, 1'b0, 1'b1, acc1);
        wait_done(++expect_done);

        foreach (vecs[i]) begin
            send(vecs[i].va, vecs[i].vb, vecs[i].vp, 1'b0, 1'b0, 1'b1, acc1);
            wait_done(++expect_done);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
